// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int N_DIG       = 3;
  localparam int SCR_W       = BCD_DIGIT_W * N_DIG;

  // Digits at or above this value would overflow past 9 when doubled.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // Double-dabble correction for a single BCD digit.
  function automatic logic [BCD_DIGIT_W-1:0] add3_fix(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= ADD3_THRESH) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/dd_step.sv
// One double-dabble step: correct every scratch digit, then shift in a bit.
module dd_step
  import bin2bcd_pkg::*;
(
  input  logic [SCR_W-1:0] scr_in,
  input  logic             bit_in,
  output logic [SCR_W-1:0] scr_out
);

  logic [SCR_W-1:0] corr;

  // Add-3 on each digit, then shift left with the incoming bit at bit 0.
  always_comb begin
    corr = scr_in;
    for (int i = 0; i < N_DIG; i++) begin
      corr[i*BCD_DIGIT_W +: BCD_DIGIT_W] = add3_fix(scr_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    // Top bit of the corrected scratch is always 0 for results <= 999.
    scr_out = SCR_W'({corr, bit_in});
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, IN_W+2 cycles per result.
module bin2bcd_seq #(
  parameter int IN_W  = 8,
  parameter int N_DIG = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [3:0]      ones,
  output logic [3:0]      tens,
  output logic [3:0]      hundreds
);

  import bin2bcd_pkg::*;

  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam int SCR_WL = BCD_DIGIT_W * N_DIG;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     sr_q, sr_d;
  logic [SCR_WL-1:0]   scr_q, scr_d;
  logic [SCR_WL-1:0]   scr_step;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          ones_q, ones_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          hund_q, hund_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // Single shared step datapath; MSB of the shift register feeds scratch bit 0.
  dd_step u_step (
    .scr_in  (scr_q),
    .bit_in  (sr_q[IN_W-1]),
    .scr_out (scr_step)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        scr_d = scr_step;
        cnt_d = cnt_q - CNT_W'(1);
        // Last step: publish digits straight from the uncorrected final shift.
        if (cnt_q == CNT_W'(1)) begin
          ones_d  = scr_step[3:0];
          tens_d  = scr_step[7:4];
          hund_d  = scr_step[11:8];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hund_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter IN_W, default 8: binary input width; legal range 1..9, so results never exceed 999.
REQ-002 SHALL have parameter N_DIG, fixed at 3: BCD digits produced (ones, tens, hundreds).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to convert bin_in; sampled only in IDLE.
REQ-006 SHALL have port bin_in  input  IN_W  unsigned binary value; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking new results valid.
REQ-009 SHALL have port ones  output  4  BCD ones digit; feeds display mux digit 0.
REQ-010 SHALL have port tens  output  4  BCD tens digit; feeds display mux digit 1.
REQ-011 SHALL have port hundreds  output  4  BCD hundreds digit; feeds display mux digit 2.

Function
REQ-012 SHALL implement a sequential shift-add-3 (double-dabble) converter with the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 on an edge SHALL perform all of the following on that edge: capture bin_in into the shift register; clear the 12-bit BCD scratch; load the step counter with IN_W; go to SHIFT.
REQ-014 Each SHIFT edge SHALL perform, in order: (1) add 3 to each scratch digit whose value is >=5; (2) shift {scratch, shift register} left by 1 bit, MSB of the shift register entering scratch bit 0; (3) decrement the counter.
REQ-015 The SHIFT edge that performs step IN_W SHALL load ones/tens/hundreds from the final scratch and go to DONE.
REQ-016 No add-3 correction SHALL be applied after the final shift.
REQ-017 DONE SHALL last exactly one cycle, with done=1, and then go to IDLE.
REQ-018 Latency: done SHALL be high in the cycle beginning IN_W edges after the edge that sampled start; this is 8 cycles at the default width.
REQ-019 Throughput: a start held high SHALL be re-accepted in the first IDLE cycle, giving one conversion per IN_W+2 cycles.
REQ-020 start SHALL be ignored while in SHIFT or DONE; the conversion in progress is unaffected.
REQ-021 Changes on bin_in after the accepting edge SHALL have no effect on the conversion in progress.
REQ-022 ones/tens/hundreds SHALL hold their last result and change only on the edge entering DONE, so the downstream mux never sees partial values.
REQ-023 Each output digit SHALL always be in the range 0..9.
REQ-024 busy SHALL be 0 exactly in IDLE.
REQ-025 done and busy SHALL be registered outputs.

Reset
REQ-026 While rst_n=0, the block SHALL immediately enter IDLE, regardless of the clock.
REQ-027 While rst_n=0, the block SHALL set busy=0, done=0, ones=0, tens=0 and hundreds=0.
REQ-028 While rst_n=0, the block SHALL set the scratch, shift register and counter to 0.
REQ-029 Reset asserted mid-conversion SHALL abort it with no done pulse, and the outputs SHALL read 0.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-031 Package bin2bcd_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), BCD_DIGIT_W=4, N_DIG=3 and the add-3 threshold constant 5.
REQ-032 Combinational sub-module dd_step SHALL perform one correct-then-shift step: inputs are the 12-bit scratch and 1 incoming bit, output is the next scratch.
REQ-033 Conversion SHALL use a single instance of dd_step per step; no unrolled array.
REQ-034 The top SHALL hold the FSM, the counter and the registers.

Verification
REQ-035 Scenario 1: reset, then start with bin_in=0 -> done after 8 cycles; ones=0, tens=0, hundreds=0.
REQ-036 Scenario 2: bin_in=255 -> hundreds=2, tens=5, ones=5; bin_in=99 -> 0/9/9; bin_in=100 -> 1/0/0.
REQ-037 Scenario 3: exhaustive sweep of 0..255 -> every result equals the decimal digits of the input; busy is high for exactly 9 cycles per conversion.
REQ-038 Scenario 4: start pulsed again during SHIFT, and bin_in changed mid-conversion -> single done; result matches the originally captured value.
REQ-039 Scenario 5: convert 123, then assert rst_n=0 at SHIFT step 4 -> no done pulse; outputs read 0/0/0; a fresh start of 42 gives 0/4/2.
REQ-040 Scenario 6: start held high continuously -> done pulses every 10 cycles; outputs stable between pulses.
